collision_detector: RTL and testbench

- Produces the `collision` level consumed by the game-state tracker. The tracker's `done` output feeds back into this block as `game_over`.
- Once per frame, on `frame_tick`, it samples the bird's Y position and scans all pipe slots through a 1-cycle-latency read port on the pipe table.
- Each pipe is tested for bird/pipe rectangle overlap, and the bird is also tested against the floor.
- Any hit latches `collision` high; it stays high until `reset`.

---
 rtl/flappy_pkg.sv | 26 ++
 rtl/collision_detector_if.sv | 15 +
 rtl/collision_detector_overlap.sv | 24 ++
 rtl/collision_detector.sv | 85 ++++++++
 tb/tb_collision_detector.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// Shared screen geometry, scan FSM states and the pipe-table record
// used by the collision detector and the pipe-table writer.
package flappy_pkg;
  localparam int COORD_W   = 10;
  localparam int SCREEN_H  = 480;
  localparam int BIRD_X    = 160;
  localparam int BIRD_SIZE = 16;
  localparam int PIPE_W    = 32;
  localparam int GAP_H     = 96;

  typedef logic [COORD_W-1:0] coord_t;
  // One extra bit so edge sums near 2^COORD_W never wrap.
  typedef logic [COORD_W:0]   ext_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, REPORT} cd_state_t;

  typedef struct packed {
    logic   valid;
    coord_t x;
    coord_t gap_y;
  } pipe_t;

  function automatic ext_t ext(input coord_t c);
    return {1'b0, c};
  endfunction
endpackage

// File: rtl/collision_detector_if.sv
// Read port between the collision detector and the pipe table (1-cycle latency).
interface collision_detector_if
  import flappy_pkg::*;
  #(parameter int N_PIPES = 4);
  localparam int IDX_W = (N_PIPES > 1) ? $clog2(N_PIPES) : 1;

  logic             pipe_rd;
  logic [IDX_W-1:0] pipe_idx;
  logic             pipe_valid;
  coord_t           pipe_x;
  coord_t           gap_y;

  modport master (output pipe_rd, pipe_idx, input pipe_valid, pipe_x, gap_y);
  modport slave  (input pipe_rd, pipe_idx, output pipe_valid, pipe_x, gap_y);
endinterface

// File: rtl/collision_detector_overlap.sv
// Combinational bird-vs-pipe rectangle test; touching edges are not a hit.
module pipe_overlap
  import flappy_pkg::*;
(
  input  coord_t bird_y_i,
  input  pipe_t  pipe_i,
  output logic   hit_o
);
  ext_t bx_l, bx_r, px_l, px_r, by_t, by_b, g_t, g_b;
  logic x_ovl, y_out;

  assign bx_l = ext_t'(BIRD_X);
  assign bx_r = ext_t'(BIRD_X + BIRD_SIZE);
  assign px_l = ext(pipe_i.x);
  assign px_r = ext(pipe_i.x) + ext_t'(PIPE_W);
  assign by_t = ext(bird_y_i);
  assign by_b = ext(bird_y_i) + ext_t'(BIRD_SIZE);
  assign g_t  = ext(pipe_i.gap_y);
  assign g_b  = ext(pipe_i.gap_y) + ext_t'(GAP_H);

  assign x_ovl = (bx_r > px_l) && (bx_l < px_r);
  assign y_out = (by_t < g_t) || (by_b > g_b);
  assign hit_o = pipe_i.valid && x_ovl && y_out;
endmodule

// File: rtl/collision_detector.sv
// Per-frame scan of the pipe table plus floor test; raises a sticky collision flag.
module collision_detector
  import flappy_pkg::*;
  #(parameter int N_PIPES = 4)
(
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic game_over,
  input  coord_t bird_y,
  collision_detector_if.master pt,
  output logic collision,
  output logic scan_done
);
  localparam int IDX_W = (N_PIPES > 1) ? $clog2(N_PIPES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PIPES - 1);

  cd_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  coord_t           by_q, by_d;
  logic             rd_q;
  logic             hit_q, hit_d;
  logic             ovl_hit, floor_hit;
  pipe_t            pipe_ret;

  assign pipe_ret  = '{valid: pt.pipe_valid, x: pt.pipe_x, gap_y: pt.gap_y};
  assign floor_hit = (ext(by_q) + ext_t'(BIRD_SIZE)) > ext_t'(SCREEN_H);

  pipe_overlap u_ovl (.bird_y_i(by_q), .pipe_i(pipe_ret), .hit_o(ovl_hit));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    by_d      = by_q;
    hit_d     = hit_q;
    pt.pipe_rd = 1'b0;
    scan_done = 1'b0;
    // rd_q marks the cycle the table data for the previous read is on the bus.
    if (rd_q && ovl_hit) hit_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (frame_tick && !game_over) begin
          by_d    = bird_y;
          state_d = FETCH;
        end
      end
      FETCH: begin
        pt.pipe_rd = 1'b1;
        if (idx_q == '0 && floor_hit) hit_d = 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN:  state_d = REPORT;
      REPORT: begin
        scan_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      by_q    <= '0;
      rd_q    <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      by_q    <= by_d;
      rd_q    <= pt.pipe_rd;
      hit_q   <= hit_d;
    end
  end

  assign pt.pipe_idx = idx_q;
  assign collision   = hit_q;
endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector with a 1-cycle-latency pipe table model.
module tb_collision_detector;
  import flappy_pkg::*;

  localparam int NK = 12;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   frame_tick = 1'b0;
  logic   game_over = 1'b0;
  coord_t bird_y = '0;
  logic   collision, scan_done;

  pipe_t tbl [4];
  int    n_chk = 0, n_fail = 0;
  int    o_rd [NK+1], o_idx [NK+1], o_done [NK+1], o_col [NK+1];

  collision_detector_if #(.N_PIPES(4)) ifc ();

  collision_detector #(.N_PIPES(4)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_over(game_over),
    .bird_y(bird_y), .pt(ifc.master), .collision(collision), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ifc.pipe_valid <= 1'b0;
    ifc.pipe_x     <= '0;
    ifc.gap_y      <= '0;
    if (ifc.pipe_rd) begin
      ifc.pipe_valid <= tbl[ifc.pipe_idx].valid;
      ifc.pipe_x     <= tbl[ifc.pipe_idx].x;
      ifc.gap_y      <= tbl[ifc.pipe_idx].gap_y;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic clr_tbl();
    for (int i = 0; i < 4; i++) tbl[i] = '{valid: 1'b0, x: '0, gap_y: '0};
  endtask

  // Tick in cycle t, then record outputs for cycles t+1..t+NK.
  // tick2_k / rst_k (0 = none) inject a second tick or a reset in cycle t+k.
  task automatic scan(input int y, input int tick2_k, input int rst_k);
    @(posedge clk); #1 frame_tick = 1'b1; bird_y = coord_t'(y);
    @(posedge clk); #1 frame_tick = 1'b0;
    for (int k = 1; k <= NK; k++) begin
      @(negedge clk);
      o_rd[k] = int'(ifc.pipe_rd); o_idx[k] = int'(ifc.pipe_idx);
      o_done[k] = int'(scan_done); o_col[k] = int'(collision);
      if (k == tick2_k) frame_tick = 1'b1;
      if (tick2_k != 0 && k == tick2_k + 1) frame_tick = 1'b0;
      if (k == rst_k) reset = 1'b1;
      if (rst_k != 0 && k == rst_k + 1) reset = 1'b0;
    end
  endtask

  function automatic int n_done();
    int s = 0;
    for (int k = 1; k <= NK; k++) s += o_done[k];
    return s;
  endfunction

  function automatic int n_rd();
    int s = 0;
    for (int k = 1; k <= NK; k++) s += o_rd[k];
    return s;
  endfunction

  initial begin
    clr_tbl();
    do_reset();
    @(negedge clk);
    check("rst_collision", int'(collision), 0);
    check("rst_scan_done", int'(scan_done), 0);
    check("rst_pipe_rd", int'(ifc.pipe_rd), 0);
    check("rst_pipe_idx", int'(ifc.pipe_idx), 0);

    // Empty table: read timing and scan_done at t+6.
    scan(200, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("empty_rd_t%0d", k), o_rd[k], 1);
      check($sformatf("empty_idx_t%0d", k), o_idx[k], k - 1);
    end
    check("empty_rd_t5", o_rd[5], 0);
    check("empty_done_t5", o_done[5], 0);
    check("empty_done_t6", o_done[6], 1);
    check("empty_done_cnt", n_done(), 1);
    check("empty_col", o_col[NK], 0);

    // Slot 2 above-gap hit: bird bottom 216 > 196.
    tbl[2] = '{valid: 1'b1, x: 10'd150, gap_y: 10'd100};
    scan(200, 0, 0);
    check("hit2_col_t4", o_col[4], 0);
    check("hit2_col_t5", o_col[5], 1);
    clr_tbl();
    scan(200, 0, 0);
    check("hit2_sticky", o_col[NK], 1);

    // Inside gap, touching right edge, and touching left edge: no hits.
    do_reset();
    tbl[2] = '{valid: 1'b1, x: 10'd150, gap_y: 10'd180};
    tbl[1] = '{valid: 1'b1, x: 10'd176, gap_y: 10'd0};
    tbl[3] = '{valid: 1'b1, x: 10'd128, gap_y: 10'd0};
    scan(200, 0, 0);
    check("gap_edge_col", o_col[NK], 0);
    // One pixel further in on the left edge overlaps (x+32=161 > 160).
    tbl[0] = '{valid: 1'b1, x: 10'd129, gap_y: 10'd0};
    scan(200, 0, 0);
    check("edge_in_col_t3", o_col[3], 1);
    clr_tbl();

    // Floor: 486 > 480 hits at t+2; 480 == 480 does not.
    do_reset();
    scan(470, 0, 0);
    check("floor_col_t1", o_col[1], 0);
    check("floor_col_t2", o_col[2], 1);
    do_reset();
    scan(464, 0, 0);
    check("floor_eq_col", o_col[NK], 0);

    // Pipe near the coordinate limit must not wrap: x=1000, x+32=1032.
    tbl[0] = '{valid: 1'b1, x: 10'd1000, gap_y: 10'd0};
    scan(200, 0, 0);
    check("nowrap_col", o_col[NK], 0);
    clr_tbl();

    // game_over blocks the start.
    game_over = 1'b1;
    scan(200, 0, 0);
    check("gover_rd_cnt", n_rd(), 0);
    check("gover_done_cnt", n_done(), 0);
    game_over = 1'b0;

    // Second tick mid-scan is ignored.
    scan(200, 3, 0);
    check("dbl_tick_done_cnt", n_done(), 1);
    check("dbl_tick_rd_cnt", n_rd(), 4);

    // Reset mid-scan with a pending slot-3 hit.
    tbl[3] = '{valid: 1'b1, x: 10'd150, gap_y: 10'd100};
    scan(200, 0, 3);
    check("mrst_rd_t3", o_rd[3], 1);
    check("mrst_rd_t4", o_rd[4], 0);
    check("mrst_col_t4", o_col[4], 0);
    check("mrst_col_end", o_col[NK], 0);
    check("mrst_done_cnt", n_done(), 0);
    check("mrst_rd_cnt", n_rd(), 3);
    clr_tbl();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
